alu: RTL and testbench
======================

# alu

8-bit, 16-operation arithmetic/logic unit with a registered 16-bit result. Each clock edge with `en` high, it evaluates operands `a` and `b` under a 4-bit command and loads the result into `dout`. It sits as a leaf datapath block under a controller that drives operands, command and enable every cycle.

## Interface
- No parameters; all widths are fixed.
- `clk`  input  1  single system clock; all state updates on the rising edge.
- `rst`  input  1  reset; synchronous, active-high.
- `a`  input  8  operand A, unsigned.
- `b`  input  8  operand B, unsigned.
- `cmd`  input  4  operation select; encoding under Operation.
- `en`  input  1  enable; result register loads only when high.
- `dout`  output  16  registered result.

## Operation
- Command encoding (`cmd` -> `dout` next value); all arithmetic is unsigned on zero-extended operands, and result width is 16 bits:
  - 0000 Add: a + b (carry lands in bit 8).
  - 0001 Inc: a + 1.
  - 0010 Sub: a − b, as 16-bit two's complement; a < b gives 0xFFxx.
  - 0011 Dec: a − 1; a = 0 gives 0xFFFF.
  - 0100 Mul: a × b, full 16-bit product.
  - 0101 Div: {8'h00, a / b}, integer quotient. For b = 0, the result is 0xFFFF.
  - 0110 Shl: a << 1; the old bit 7 goes to bit 8.
  - 0111 Shr: a >> 1, logical.
  - 1000 And: a & b.
  - 1001 Or: a | b.
  - 1010 Inv: ~a; b is ignored.
  - 1011 Nand: ~(a & b).
  - 1100 Nor: ~(a | b).
  - 1101 Xor: a ^ b.
  - 1110 Xnor: ~(a ^ b).
  - 1111 Buf: a.
- Logic, Inv and Buf operate on 8 bits. `dout[15:8]` = 0 for these.
- The encoding is complete, so there is no illegal `cmd`.
- `en` = 0: `dout` holds its previous value. Operands and `cmd` are don't-care.
- No internal state other than the `dout` register.

## Timing
- Latency 1 cycle: operands, `cmd` and `en` are sampled at rising edge N, and the result is visible on `dout` after edge N.
- Throughput 1 operation per cycle; back-to-back commands need no idle cycles.
- Reset: `rst` high at an edge forces `dout` to 0x0000, overriding `en` and `cmd`.
  - Reset asserted mid-stream discards the in-flight operation.
  - The first edge with `rst` low and `en` high loads a normal result.
- The combinational path from `a`/`b`/`cmd` to the register includes the 8×8 multiplier and the 8-bit divider. Both must complete within one cycle; there is no multicycle path.
- Inputs changing between edges have no effect on `dout`, which has no combinational path from inputs.

## Test plan
- Reset: assert `rst` for 2 edges with arbitrary inputs and `en` = 1 -> `dout` = 0x0000. Release, then a=10, b=10, Add -> `dout` = 0x0014 after the next edge.
- Basic arithmetic, `en` = 1, one op per cycle:
  - a=20, b=10, Sub -> 0x000A.
  - a=10, b=10, Mul -> 0x0064.
  - a=10, b=20, Sub -> 0xFFF6.
- Width/overflow boundaries:
  - a=0xFF, b=0xFF, Add -> 0x01FE; Mul -> 0xFE01.
  - a=0xFF, Inc -> 0x0100.
  - a=0x00, Dec -> 0xFFFF.
  - a=0x81, Shl -> 0x0102; Shr -> 0x0040.
- Division:
  - a=100, b=7 -> 0x000E.
  - a=5, b=0 -> 0xFFFF.
- Logic ops, a=0xCA, b=0x5C:
  - And 0x0048, Or 0x00DE, Xor 0x0096, Nand 0x00B7, Nor 0x0021, Xnor 0x0069, Inv 0x0035, Buf 0x00CA.
- Enable hold: load Add result 0x0014, then `en` = 0 while changing a, b and `cmd` for 3 cycles -> `dout` stays 0x0014. Then `en` = 1 with Mul 3×4 -> 0x000C after one edge.

Source files
------------

// File: rtl/alu.sv
// alu: 8-bit, 16-operation arithmetic/logic unit with a registered 16-bit result.
// Operands are unsigned and zero-extended; the whole datapath (including the
// 8x8 multiplier and 8-bit divider) settles within a single cycle.
module alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic [3:0]  cmd,
  input  logic        en,
  output logic [15:0] dout
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_INC  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_DEC  = 4'b0011;
  localparam logic [3:0] OP_MUL  = 4'b0100;
  localparam logic [3:0] OP_DIV  = 4'b0101;
  localparam logic [3:0] OP_SHL  = 4'b0110;
  localparam logic [3:0] OP_SHR  = 4'b0111;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_OR   = 4'b1001;
  localparam logic [3:0] OP_INV  = 4'b1010;
  localparam logic [3:0] OP_NAND = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_XOR  = 4'b1101;
  localparam logic [3:0] OP_XNOR = 4'b1110;
  localparam logic [3:0] OP_BUF  = 4'b1111;

  logic [15:0] a_ext;
  logic [15:0] b_ext;
  logic [7:0]  quot;
  logic [15:0] result;

  assign a_ext = {8'h00, a};
  assign b_ext = {8'h00, b};

  // Divider quotient; a zero divisor is flagged separately in the result mux,
  // so the quotient value for b = 0 is forced to a harmless constant here.
  always_comb begin
    quot = 8'h00;
    if (b != 8'h00) begin
      quot = a / b;
    end
  end

  // Operation select: arithmetic on 16-bit zero-extended operands, logic ops
  // on 8 bits with the upper byte cleared.
  always_comb begin
    result = 16'h0000;
    case (cmd)
      OP_ADD:  result = a_ext + b_ext;
      OP_INC:  result = a_ext + 16'd1;
      OP_SUB:  result = a_ext - b_ext;
      OP_DEC:  result = a_ext - 16'd1;
      OP_MUL:  result = a_ext * b_ext;
      OP_DIV:  result = (b == 8'h00) ? 16'hFFFF : {8'h00, quot};
      OP_SHL:  result = {7'b0, a, 1'b0};
      OP_SHR:  result = {9'b0, a[7:1]};
      OP_AND:  result = {8'h00, a & b};
      OP_OR:   result = {8'h00, a | b};
      OP_INV:  result = {8'h00, ~a};
      OP_NAND: result = {8'h00, ~(a & b)};
      OP_NOR:  result = {8'h00, ~(a | b)};
      OP_XOR:  result = {8'h00, a ^ b};
      OP_XNOR: result = {8'h00, ~(a ^ b)};
      OP_BUF:  result = {8'h00, a};
      default: result = 16'h0000;
    endcase
  end

  // Result register: reset wins over enable; en low holds the last result.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= 16'h0000;
    end else if (en) begin
      dout <= result;
    end
  end

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed vectors with literal expectations, plus a cycle-by-cycle
// comparison of dout against an integer-arithmetic reference model.
module tb_alu;

  logic        clk;
  logic        rst;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [3:0]  cmd;
  logic        en;
  logic [15:0] dout;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit checking  = 0;
  logic [15:0] model_dout;

  alu dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .cmd  (cmd),
    .en   (en),
    .dout (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result from plain integer arithmetic on the operation's meaning.
  function automatic logic [15:0] model_op(input logic [7:0] ma, input logic [7:0] mb,
                                           input logic [3:0] mc);
    int ia, ib, r;
    ia = int'(ma);
    ib = int'(mb);
    case (mc)
      4'd0:  r = ia + ib;
      4'd1:  r = ia + 1;
      4'd2:  r = ia - ib;
      4'd3:  r = ia - 1;
      4'd4:  r = ia * ib;
      4'd5:  r = (ib == 0) ? 65535 : ia / ib;
      4'd6:  r = ia * 2;
      4'd7:  r = ia / 2;
      4'd8:  r = ia & ib;
      4'd9:  r = ia | ib;
      4'd10: r = 255 - ia;
      4'd11: r = 255 - (ia & ib);
      4'd12: r = 255 - (ia | ib);
      4'd13: r = ia ^ ib;
      4'd14: r = 255 - (ia ^ ib);
      default: r = ia;
    endcase
    return r[15:0];
  endfunction

  // Model register tracking what dout must hold after each edge.
  always @(posedge clk) begin
    if (rst) model_dout = 16'h0000;
    else if (en) model_dout = model_op(a, b, cmd);
  end

  // Continuous compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      total_cnt++;
      if (dout === model_dout) pass_cnt++;
      else $display("FAIL model_cmp t=%0t: dout=%h model=%h", $time, dout, model_dout);
    end
  end

  task automatic step(input logic [7:0] ta, input logic [7:0] tb_v, input logic [3:0] tc,
                      input logic te, input logic tr);
    @(negedge clk);
    a = ta; b = tb_v; cmd = tc; en = te; rst = tr;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] exp);
    total_cnt++;
    if (dout === exp) pass_cnt++;
    else $display("FAIL %s: dout=%h expected=%h", name, dout, exp);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; a = 8'h00; b = 8'h00; cmd = 4'h0;

    // Reset with enable high and arbitrary operands.
    step(8'h55, 8'h33, 4'd4, 1'b1, 1'b1);
    checking = 1;
    check("reset_edge1", 16'h0000);
    step(8'hAA, 8'h0F, 4'd0, 1'b1, 1'b1);
    check("reset_edge2", 16'h0000);
    step(8'd10, 8'd10, 4'd0, 1'b1, 1'b0);
    check("add_after_reset", 16'h0014);

    // Basic arithmetic, back to back.
    step(8'd20, 8'd10, 4'd2, 1'b1, 1'b0); check("sub_20_10", 16'h000A);
    step(8'd10, 8'd10, 4'd4, 1'b1, 1'b0); check("mul_10_10", 16'h0064);
    step(8'd10, 8'd20, 4'd2, 1'b1, 1'b0); check("sub_10_20", 16'hFFF6);

    // Width and overflow boundaries.
    step(8'hFF, 8'hFF, 4'd0, 1'b1, 1'b0); check("add_ff_ff", 16'h01FE);
    step(8'hFF, 8'hFF, 4'd4, 1'b1, 1'b0); check("mul_ff_ff", 16'hFE01);
    step(8'hFF, 8'h00, 4'd1, 1'b1, 1'b0); check("inc_ff", 16'h0100);
    step(8'h00, 8'h00, 4'd3, 1'b1, 1'b0); check("dec_00", 16'hFFFF);
    step(8'h81, 8'h00, 4'd6, 1'b1, 1'b0); check("shl_81", 16'h0102);
    step(8'h81, 8'h00, 4'd7, 1'b1, 1'b0); check("shr_81", 16'h0040);

    // Division including zero divisor.
    step(8'd100, 8'd7, 4'd5, 1'b1, 1'b0); check("div_100_7", 16'h000E);
    step(8'd5, 8'd0, 4'd5, 1'b1, 1'b0);   check("div_by_zero", 16'hFFFF);

    // Logic ops on a=0xCA, b=0x5C.
    step(8'hCA, 8'h5C, 4'd8,  1'b1, 1'b0); check("and",  16'h0048);
    step(8'hCA, 8'h5C, 4'd9,  1'b1, 1'b0); check("or",   16'h00DE);
    step(8'hCA, 8'h5C, 4'd13, 1'b1, 1'b0); check("xor",  16'h0096);
    step(8'hCA, 8'h5C, 4'd11, 1'b1, 1'b0); check("nand", 16'h00B7);
    step(8'hCA, 8'h5C, 4'd12, 1'b1, 1'b0); check("nor",  16'h0021);
    step(8'hCA, 8'h5C, 4'd14, 1'b1, 1'b0); check("xnor", 16'h0069);
    step(8'hCA, 8'h5C, 4'd10, 1'b1, 1'b0); check("inv",  16'h0035);
    step(8'hCA, 8'h5C, 4'd15, 1'b1, 1'b0); check("buf",  16'h00CA);

    // Enable hold.
    step(8'd10, 8'd10, 4'd0, 1'b1, 1'b0); check("hold_load", 16'h0014);
    step(8'd77, 8'd3,  4'd4, 1'b0, 1'b0); check("hold_1", 16'h0014);
    step(8'd1,  8'd200, 4'd2, 1'b0, 1'b0); check("hold_2", 16'h0014);
    step(8'hF0, 8'h0F, 4'd9, 1'b0, 1'b0); check("hold_3", 16'h0014);
    step(8'd3,  8'd4,  4'd4, 1'b1, 1'b0); check("mul_3_4", 16'h000C);

    // Reset mid-stream discards the in-flight op, then normal operation resumes.
    step(8'd9, 8'd9, 4'd4, 1'b1, 1'b1);   check("reset_midstream", 16'h0000);
    step(8'd9, 8'd9, 4'd4, 1'b1, 1'b0);   check("mul_after_reset", 16'h0051);

    // Random traffic covered by the model compare.
    for (int i = 0; i < 200; i++) begin
      step(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
           4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 31) == 0));
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
